// File: rtl/ifc_add_sched.sv
// Round-robin two-requester job scheduler in front of the ifc_add engine (len, N data, result).
// Optional per-requester job counters jobs0/jobs1 are enabled with `define IFC_SCHED_STATS_EN.
module ifc_add_sched #(
  parameter int LEN_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rq0_req,
  input  logic              rq1_req,
  input  logic [LEN_W-1:0]  rq0_len_value,
  input  logic [LEN_W-1:0]  rq1_len_value,
  input  logic              rq0_len_en,
  input  logic              rq1_len_en,
  output logic              rq0_len_rdy,
  output logic              rq1_len_rdy,
  input  logic [DATA_W-1:0] rq0_din_value,
  input  logic [DATA_W-1:0] rq1_din_value,
  input  logic              rq0_din_en,
  input  logic              rq1_din_en,
  output logic              rq0_din_rdy,
  output logic              rq1_din_rdy,
  input  logic              rq0_dout_en,
  input  logic              rq1_dout_en,
  output logic [DATA_W-1:0] rq0_dout_value,
  output logic [DATA_W-1:0] rq1_dout_value,
  output logic              rq0_dout_rdy,
  output logic              rq1_dout_rdy,
  output logic [LEN_W-1:0]  eng_len_value,
  output logic              eng_len_en,
  input  logic              eng_len_rdy,
  output logic [DATA_W-1:0] eng_din_value,
  output logic              eng_din_en,
  input  logic              eng_din_rdy,
  input  logic [DATA_W-1:0] eng_dout_value,
  output logic              eng_dout_en,
  input  logic              eng_dout_rdy,
  output logic              busy,
  output logic              gnt
`ifdef IFC_SCHED_STATS_EN
  ,
  output logic [15:0]       jobs0,
  output logic [15:0]       jobs1
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_RESULT} state_t;

  state_t             state_q, state_d;
  logic               gnt_q, gnt_d, last_q, last_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic               len_rdy, din_rdy, dout_rdy;
  logic [DATA_W-1:0]  dout_value;
  logic               result_xfer;

  // Requester-side signals of whoever currently holds the grant
  logic               sel_len_en, sel_din_en, sel_dout_en;
  logic [LEN_W-1:0]   sel_len_value;
  logic [DATA_W-1:0]  sel_din_value;

  assign sel_len_en    = gnt_q ? rq1_len_en    : rq0_len_en;
  assign sel_din_en    = gnt_q ? rq1_din_en    : rq0_din_en;
  assign sel_dout_en   = gnt_q ? rq1_dout_en   : rq0_dout_en;
  assign sel_len_value = gnt_q ? rq1_len_value : rq0_len_value;
  assign sel_din_value = gnt_q ? rq1_din_value : rq0_din_value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_d        = last_q;
    count_d       = count_q;
    len_rdy       = 1'b0;
    din_rdy       = 1'b0;
    dout_rdy      = 1'b0;
    dout_value    = '0;
    eng_len_en    = 1'b0;
    eng_len_value = '0;
    eng_din_en    = 1'b0;
    eng_din_value = '0;
    eng_dout_en   = 1'b0;
    result_xfer   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rq0_req || rq1_req) begin
          // On a tie the requester not served last wins
          gnt_d   = (rq0_req && rq1_req) ? ~last_q : rq1_req;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        len_rdy       = eng_len_rdy;
        eng_len_en    = sel_len_en;
        eng_len_value = sel_len_value;
        if (eng_len_rdy && sel_len_en) begin
          count_d = sel_len_value;
          state_d = (sel_len_value == '0) ? S_RESULT : S_DATA;
        end
      end
      S_DATA: begin
        din_rdy       = eng_din_rdy;
        eng_din_en    = sel_din_en;
        eng_din_value = sel_din_value;
        if (eng_din_rdy && sel_din_en) begin
          if (count_q != '0) count_d = count_q - LEN_W'(1);
          if (count_q == LEN_W'(1)) state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        dout_rdy    = eng_dout_rdy;
        dout_value  = eng_dout_value;
        eng_dout_en = sel_dout_en;
        if (eng_dout_rdy && sel_dout_en) begin
          result_xfer = 1'b1;
          last_d      = gnt_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rq0_len_rdy    = len_rdy  & ~gnt_q;
  assign rq1_len_rdy    = len_rdy  &  gnt_q;
  assign rq0_din_rdy    = din_rdy  & ~gnt_q;
  assign rq1_din_rdy    = din_rdy  &  gnt_q;
  assign rq0_dout_rdy   = dout_rdy & ~gnt_q;
  assign rq1_dout_rdy   = dout_rdy &  gnt_q;
  assign rq0_dout_value = gnt_q ? '0 : dout_value;
  assign rq1_dout_value = gnt_q ? dout_value : '0;
  assign busy           = (state_q != S_IDLE);
  assign gnt            = gnt_q;

`ifdef IFC_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jobs0 <= '0;
      jobs1 <= '0;
    end else if (result_xfer) begin
      if (gnt_q) jobs1 <= jobs1 + 16'd1;
      else       jobs0 <= jobs0 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifc_add_sched.sv
// Bench for ifc_add_sched: the bench plays both requesters and the engine, with a job-level
// arbitration model (last served, job counts) and random handshake timing.
module tb_ifc_add_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rq_req [2];
  logic [7:0] rq_len_value [2];
  logic       rq_len_en [2];
  logic       rq_len_rdy [2];
  logic [7:0] rq_din_value [2];
  logic       rq_din_en [2];
  logic       rq_din_rdy [2];
  logic       rq_dout_en [2];
  logic       rq_dout_rdy [2];
  logic [7:0] rq_dout_value [2];
  logic [7:0] eng_len_value, eng_din_value, eng_dout_value;
  logic       eng_len_en, eng_len_rdy, eng_din_en, eng_din_rdy, eng_dout_en, eng_dout_rdy;
  logic       busy, gnt;
`ifdef IFC_SCHED_STATS_EN
  logic [15:0] jobs0, jobs1;
`endif

  int errors = 0;
  int checks = 0;
  int m_last = 1;
  int m_jobs [2] = '{0, 0};
  logic [7:0] fixed_din [$];

  always #5 clk = ~clk;

  ifc_add_sched dut (
    .clk(clk), .rst(rst),
    .rq0_req(rq_req[0]), .rq1_req(rq_req[1]),
    .rq0_len_value(rq_len_value[0]), .rq1_len_value(rq_len_value[1]),
    .rq0_len_en(rq_len_en[0]), .rq1_len_en(rq_len_en[1]),
    .rq0_len_rdy(rq_len_rdy[0]), .rq1_len_rdy(rq_len_rdy[1]),
    .rq0_din_value(rq_din_value[0]), .rq1_din_value(rq_din_value[1]),
    .rq0_din_en(rq_din_en[0]), .rq1_din_en(rq_din_en[1]),
    .rq0_din_rdy(rq_din_rdy[0]), .rq1_din_rdy(rq_din_rdy[1]),
    .rq0_dout_en(rq_dout_en[0]), .rq1_dout_en(rq_dout_en[1]),
    .rq0_dout_value(rq_dout_value[0]), .rq1_dout_value(rq_dout_value[1]),
    .rq0_dout_rdy(rq_dout_rdy[0]), .rq1_dout_rdy(rq_dout_rdy[1]),
    .eng_len_value(eng_len_value), .eng_len_en(eng_len_en), .eng_len_rdy(eng_len_rdy),
    .eng_din_value(eng_din_value), .eng_din_en(eng_din_en), .eng_din_rdy(eng_din_rdy),
    .eng_dout_value(eng_dout_value), .eng_dout_en(eng_dout_en), .eng_dout_rdy(eng_dout_rdy),
    .busy(busy), .gnt(gnt)
`ifdef IFC_SCHED_STATS_EN
    , .jobs0(jobs0), .jobs1(jobs1)
`endif
  );

  task automatic clear_strobes();
    for (int i = 0; i < 2; i++) begin
      rq_len_en[i] = 1'b0; rq_din_en[i] = 1'b0; rq_dout_en[i] = 1'b0;
    end
  endtask

  // One complete job on whichever requester the arbitration model says wins.
  // Called and returns at a negedge with the scheduler idle.
  task automatic run_job(input logic [7:0] len, input bit keep, input int stall_at, output int g);
    int exp_g, stall_cnt;
    bit done;
    logic [7:0] d, res;
    exp_g = (rq_req[0] && rq_req[1]) ? (m_last == 1 ? 0 : 1) : (rq_req[1] ? 1 : 0);
    @(posedge clk); @(negedge clk);
    checks++;
    if (busy !== 1'b1 || gnt !== exp_g[0]) begin
      errors++; $display("FAIL grant: busy=%0b gnt=%0b required busy=1 gnt=%0d", busy, gnt, exp_g);
    end
    g = exp_g;
    if (!keep) rq_req[g] = 1'b0;
    rq_len_value[g] = len;
    rq_din_value[g] = 8'hA5;
    done = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      eng_len_rdy = ($urandom_range(0, 3) != 0);
      eng_din_rdy = 1'b1; eng_dout_rdy = 1'b1;
      #1 rq_len_en[g] = rq_len_rdy[g];
      #1 checks++;
      if (rq_len_rdy[g] !== eng_len_rdy || rq_len_rdy[1-g] !== 1'b0 || eng_len_en !== eng_len_rdy ||
          eng_len_value !== len || rq_din_rdy[g] !== 1'b0 || rq_dout_rdy[g] !== 1'b0 ||
          eng_din_value !== 8'h00 || eng_din_en !== 1'b0 || eng_dout_en !== 1'b0) begin
        errors++;
        $display("FAIL len_route: len_rdy=%0b/%0b eng_len_rdy=%0b eng_len_en=%0b eng_len_value=%0d required %0d din_rdy=%0b dout_rdy=%0b eng_din_value=%0d",
                 rq_len_rdy[g], rq_len_rdy[1-g], eng_len_rdy, eng_len_en, eng_len_value, len,
                 rq_din_rdy[g], rq_dout_rdy[g], eng_din_value);
      end
      if (eng_len_rdy) done = 1; else @(negedge clk);
    end
    if (!done) begin errors++; $display("FAIL len_timeout: no length transfer within budget"); end
    @(posedge clk); @(negedge clk);
    rq_len_en[g] = 1'b0;
    for (int i = 0; i < len; i++) begin
      d = 8'($urandom);
      if (fixed_din.size() > 0) d = fixed_din.pop_front();
      rq_din_value[g] = d;
      stall_cnt = (i == stall_at) ? 4 : 0;
      done = 0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
        eng_din_rdy = (stall_cnt > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (stall_cnt > 0) stall_cnt--;
        eng_len_rdy = 1'b1; eng_dout_rdy = 1'b1;
        #1 rq_din_en[g] = rq_din_rdy[g];
        #1 checks++;
        if (rq_din_rdy[g] !== eng_din_rdy || rq_din_rdy[1-g] !== 1'b0 || eng_din_en !== eng_din_rdy ||
            eng_din_value !== d || rq_len_rdy[g] !== 1'b0 || rq_dout_rdy[g] !== 1'b0 ||
            eng_len_value !== 8'h00 || eng_len_en !== 1'b0 || eng_dout_en !== 1'b0) begin
          errors++;
          $display("FAIL din_route beat %0d: din_rdy=%0b eng_din_rdy=%0b eng_din_en=%0b eng_din_value=%0d required %0d len_rdy=%0b dout_rdy=%0b eng_len_value=%0d",
                   i, rq_din_rdy[g], eng_din_rdy, eng_din_en, eng_din_value, d, rq_len_rdy[g],
                   rq_dout_rdy[g], eng_len_value);
        end
        if (eng_din_rdy) done = 1; else @(negedge clk);
      end
      if (!done) begin errors++; $display("FAIL din_timeout: beat %0d not taken", i); end
      @(posedge clk); @(negedge clk);
      rq_din_en[g] = 1'b0;
    end
    res = 8'($urandom);
    eng_dout_value = res;
    rq_din_value[g] = 8'h3C;
    done = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      eng_dout_rdy = ($urandom_range(0, 3) != 0);
      eng_len_rdy = 1'b1; eng_din_rdy = 1'b1;
      #1 rq_dout_en[g] = rq_dout_rdy[g];
      #1 checks++;
      if (rq_dout_rdy[g] !== eng_dout_rdy || rq_dout_rdy[1-g] !== 1'b0 || eng_dout_en !== eng_dout_rdy ||
          rq_dout_value[g] !== res || rq_dout_value[1-g] !== 8'h00 || rq_din_rdy[g] !== 1'b0 ||
          rq_len_rdy[g] !== 1'b0 || eng_din_value !== 8'h00 || eng_din_en !== 1'b0) begin
        errors++;
        $display("FAIL dout_route: dout_rdy=%0b eng_dout_rdy=%0b eng_dout_en=%0b dout_value=%0d required %0d other_value=%0d din_rdy=%0b len_rdy=%0b eng_din_value=%0d",
                 rq_dout_rdy[g], eng_dout_rdy, eng_dout_en, rq_dout_value[g], res,
                 rq_dout_value[1-g], rq_din_rdy[g], rq_len_rdy[g], eng_din_value);
      end
      if (eng_dout_rdy) done = 1; else @(negedge clk);
    end
    if (!done) begin errors++; $display("FAIL dout_timeout: result not taken"); end
    m_last = g;
    m_jobs[g]++;
    @(posedge clk); @(negedge clk);
    rq_dout_en[g] = 1'b0;
    eng_len_rdy = 1'b1; eng_din_rdy = 1'b1; eng_dout_rdy = 1'b1;
    #1 checks++;
    if (busy !== 1'b0 || rq_len_rdy[0] !== 1'b0 || rq_len_rdy[1] !== 1'b0 || rq_din_rdy[0] !== 1'b0 ||
        rq_din_rdy[1] !== 1'b0 || rq_dout_rdy[0] !== 1'b0 || rq_dout_rdy[1] !== 1'b0 ||
        rq_dout_value[g] !== 8'h00 || eng_len_en !== 1'b0 || eng_dout_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_gap: busy=%0b required 0, rdy or en not all 0 after result transfer", busy);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rq_req[i] = 1'b0; rq_len_value[i] = 8'h11; rq_din_value[i] = 8'h22;
    end
    clear_strobes();
    eng_len_rdy = 1'b1; eng_din_rdy = 1'b1; eng_dout_rdy = 1'b1; eng_dout_value = 8'h77;
    rst = 1'b1;
    #12 checks++;
    if (busy !== 1'b0 || gnt !== 1'b0 || eng_len_en !== 1'b0 || eng_din_en !== 1'b0 ||
        eng_dout_en !== 1'b0 || eng_len_value !== 8'h00 || eng_din_value !== 8'h00 ||
        rq_dout_value[0] !== 8'h00 || rq_dout_value[1] !== 8'h00 || rq_len_rdy[0] !== 1'b0 ||
        rq_din_rdy[1] !== 1'b0 || rq_dout_rdy[0] !== 1'b0) begin
      errors++; $display("FAIL reset_state: busy=%0b gnt=%0b outputs not all 0 in reset", busy, gnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int g;
    int seq [3] = '{0, 1, 0};
    rq_req[0] = 1'b1; rq_req[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) rq_req[1] = 1'b0;
      run_job(8'($urandom_range(1, 3)), k != 2, -1, g);
      checks++;
      if (gnt !== seq[k][0]) begin
        errors++; $display("FAIL rr_sequence job %0d: gnt=%0b required %0d", k, gnt, seq[k]);
      end
    end
  endtask

  task automatic test_single();
    int g;
    fixed_din = '{8'd5, 8'd7, 8'd9};
    rq_req[0] = 1'b1;
    run_job(8'd3, 1'b0, -1, g);
    checks++;
    if (gnt !== 1'b0 || fixed_din.size() != 0) begin
      errors++; $display("FAIL single_job: gnt=%0b required 0, din beats left=%0d required 0", gnt, fixed_din.size());
    end
  endtask

  task automatic test_zero_len();
    int g;
    rq_req[1] = 1'b1;
    run_job(8'd0, 1'b0, -1, g);
  endtask

  task automatic test_stall();
    int g;
    rq_req[0] = 1'b1;
    run_job(8'd6, 1'b0, 2, g);
  endtask

  task automatic test_reset_mid_job();
    int g;
    rq_req[1] = 1'b1;
    eng_len_rdy = 1'b1; eng_din_rdy = 1'b1; eng_dout_rdy = 1'b1;
    @(posedge clk); @(negedge clk);
    rq_req[1] = 1'b0;
    rq_len_value[1] = 8'd5; rq_len_en[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    rq_len_en[1] = 1'b0; rq_din_en[1] = 1'b1; rq_din_value[1] = 8'h44;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    checks++;
    if (busy !== 1'b1 || gnt !== 1'b1 || rq_din_rdy[1] !== 1'b1 || eng_din_en !== 1'b1) begin
      errors++; $display("FAIL pre_reset_data: busy=%0b gnt=%0b din_rdy=%0b eng_din_en=%0b required 1 1 1 1",
                         busy, gnt, rq_din_rdy[1], eng_din_en);
    end
    rst = 1'b1;
    #1 checks++;
    if (busy !== 1'b0 || gnt !== 1'b0 || rq_din_rdy[1] !== 1'b0 || eng_din_en !== 1'b0 ||
        eng_din_value !== 8'h00 || rq_len_rdy[1] !== 1'b0 || rq_dout_rdy[1] !== 1'b0) begin
      errors++; $display("FAIL reset_mid_job: busy=%0b gnt=%0b din_rdy=%0b eng_din_en=%0b required all 0",
                         busy, gnt, rq_din_rdy[1], eng_din_en);
    end
    m_last = 1; m_jobs[0] = 0; m_jobs[1] = 0;
`ifdef IFC_SCHED_STATS_EN
    checks++;
    if (jobs0 !== 16'd0 || jobs1 !== 16'd0) begin
      errors++; $display("FAIL stats_reset: jobs0=%0d jobs1=%0d required 0 0", jobs0, jobs1);
    end
`endif
    @(negedge clk);
    clear_strobes();
    rst = 1'b0;
    rq_req[0] = 1'b1; rq_req[1] = 1'b1;
    run_job(8'd2, 1'b0, -1, g);
    run_job(8'd1, 1'b0, -1, g);
  endtask

  task automatic test_random();
    int g, p;
    for (int k = 0; k < 10; k++) begin
      if (!rq_req[0] && !rq_req[1]) begin
        p = $urandom_range(1, 3);
        rq_req[0] = p[0]; rq_req[1] = p[1];
      end
      run_job(8'($urandom_range(0, 4)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1 ? 0 : -1, g);
    end
    rq_req[0] = 1'b0; rq_req[1] = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL random_end_idle: busy=%0b required 0", busy); end
`ifdef IFC_SCHED_STATS_EN
    checks++;
    if (jobs0 !== 16'(m_jobs[0]) || jobs1 !== 16'(m_jobs[1])) begin
      errors++; $display("FAIL stats_counts: jobs0=%0d jobs1=%0d required %0d %0d", jobs0, jobs1, m_jobs[0], m_jobs[1]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_zero_len();
    test_stall();
    test_reset_mid_job();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
